aes_decrypt_iter: RTL

AES_DECRYPT_ITER -- requirements
Module: aes_decrypt_iter

---
 rtl/aes_pkg.sv | 84 ++++++++
 rtl/inv_sbox.sv | 32 +++
 rtl/aes_decrypt_iter.sv | 95 +++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative decryptor: block layout, FSM
// states, GF(2^8) arithmetic and the inverse round transforms.
package aes_pkg;

  // Columns per state; the state is always 4x4 bytes.
  localparam int Nb = 4;

  // 128-bit block, byte k at bits [8k:8k+7], column-major (bytes 0-3 = column 0).
  typedef logic [0:127] block_t;

  // Sequencer states of the decryptor.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  // Multiply by x in GF(2^8), reducing by 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) product; the callers only use constant multipliers,
  // so this collapses to a few XOR terms per bit.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] pow;
    acc = 8'h00;
    pow = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        acc = acc ^ pow;
      end
      pow = xtime(pow);
    end
    return acc;
  endfunction

  // InvShiftRows source index: row r of column c comes from column c-r.
  // Gives out[1]<-in[13], out[5]<-in[1], out[2]<-in[10], out[3]<-in[7].
  function automatic int isr_src(input int k);
    int col;
    int row;
    col = k / Nb;
    row = k % Nb;
    return Nb * ((col - row + Nb) % Nb) + row;
  endfunction

  // Whole-block InvShiftRows, a pure byte permutation.
  function automatic block_t inv_shift_rows(input block_t s);
    block_t o;
    o = '0;
    for (int k = 0; k < 4 * Nb; k++) begin
      o[8*k +: 8] = s[8*isr_src(k) +: 8];
    end
    return o;
  endfunction

  // One InvMixColumns column; bits [31:24] hold the row-0 byte.
  function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    b0 = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
    b1 = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
    b2 = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
    b3 = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    return {b0, b1, b2, b3};
  endfunction

  // Whole-block InvMixColumns, column by column.
  function automatic block_t inv_mix_columns(input block_t s);
    block_t o;
    o = '0;
    for (int c = 0; c < Nb; c++) begin
      o[32*c +: 32] = inv_mix_column(s[32*c +: 32]);
    end
    return o;
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box, one byte in, one byte out.
module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Inverse S-box table, entry n at bits [8n:8n+7]; one row per high nibble.
  localparam logic [0:2047] inv_table = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Table lookup; the byte value scaled by 8 addresses its entry.
  always_comb begin
    y = inv_table[{a, 3'b000} +: 8];
  end

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES decryptor: one inverse round per clock through a single
// combinational round datapath, with the state register as the only stage.
module aes_decrypt_iter
  import aes_pkg::*;
#(
  parameter int nk = 4,
  parameter int nr = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [0:127]          in,
  input  logic [0:128*(nr+1)-1] key_e,
  output logic                  ready,
  output logic                  done,
  output logic [0:127]          out
);

  // nk only documents the key size; it has to name the same variant as nr.
  if (nr != nk + 6) begin : g_param_check
    $error("aes_decrypt_iter: nk and nr do not describe the same AES variant");
  end

  fsm_state_t fsm;
  logic [3:0] rnd;
  block_t     state;

  block_t shifted;
  block_t subbed;
  block_t round_key;
  block_t keyed;
  block_t mixed;

  // Round key for the current round counter; 128-bit keys start at rnd*128.
  assign round_key = key_e[{rnd, 7'b0000000} +: 128];

  // InvShiftRows is wiring only.
  assign shifted = inv_shift_rows(state);

  // Sixteen inverse S-boxes, shared by the middle rounds and the final round.
  for (genvar g = 0; g < 16; g++) begin : g_sbox
    inv_sbox u_inv_sbox (
      .a(shifted[8*g +: 8]),
      .y(subbed[8*g +: 8])
    );
  end

  // keyed is the final-round result; mixed feeds the next middle round.
  assign keyed = subbed ^ round_key;
  assign mixed = inv_mix_columns(keyed);

  // Sequencer: capture with the last round key, iterate down to round 0,
  // then pulse done for one cycle before becoming ready again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm   <= IDLE;
      rnd   <= 4'd0;
      state <= '0;
      out   <= '0;
      done  <= 1'b0;
      ready <= 1'b1;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            state <= in ^ key_e[128*nr +: 128];
            rnd   <= 4'(nr - 1);
            ready <= 1'b0;
            fsm   <= RUN;
          end
        end
        RUN: begin
          if (rnd != 4'd0) begin
            state <= mixed;
            rnd   <= rnd - 4'd1;
          end else begin
            out  <= keyed;
            done <= 1'b1;
            fsm  <= DONE;
          end
        end
        DONE: begin
          ready <= 1'b1;
          fsm   <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          fsm   <= IDLE;
        end
      endcase
    end
  end

endmodule
